branch_resolve_unit: RTL and testbench

- EXE-stage branch resolver; consumes the IF prediction (PResult, carried down the pipe) and the actual branch outcome computed in EXE.
- Produces the BResult training/correction packet consumed by the BPU.
- Produces the front-end redirect (PC + IF flush), honouring the MIPS delay slot.
- Holds one-shot reporting state across EXE stalls and keeps branch/mispredict performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 47 ++++
 rtl/branch_resolve_unit_sat_counter.sv | 35 +++
 rtl/branch_resolve_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared CPU definitions: branch type encoding, the IF prediction packet
// carried down the pipe, the BPU training packet and the resolver FSM states.
package CPU_Defines;

   // Decoded branch class as produced by ID.
   typedef enum logic [1:0] {
      BIsNone = 2'd0,
      BIsCall = 2'd1,
      BIsRetn = 2'd2,
      BIsImme = 2'd3
   } btype_t;

   // Prediction made in IF, travelling with the instruction.
   typedef struct packed {
      logic        Valid;
      logic        IsTaken;
      logic [31:0] Target;
      logic [1:0]  Count;
      logic        Hit;
   } PResult;

   // Training / correction packet sent back to the BPU.
   typedef struct packed {
      logic        Valid;
      logic [31:0] PC;
      btype_t      Type;
      logic [31:0] Target;
      logic        IsTaken;
      logic [1:0]  Count;
      logic        Hit;
   } BResult;

   // Resolver state: idle, or holding a correction until the delay slot is in.
   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_DS = 1'b1
   } brs_state_t;

   // Fall-through distance past a branch and its delay slot.
   localparam logic [31:0] DS_STEP = 32'd8;

   // Sequential successor of a branch, skipping its delay slot (wraps at 2^32).
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + DS_STEP;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next value: hold at all-ones instead of wrapping back to zero.
   always_comb begin
      // NOTE: give every combinational output a default first so no path leaves it unassigned (that would infer a latch).
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EXE-stage branch resolver: compares the IF prediction against the actual
// outcome, emits the BPU training packet, redirects the front end after the
// delay slot has been fetched, and keeps branch/mispredict counters.
module branch_resolve_unit
   import CPU_Defines::*;
#(
   parameter int CNT_W        = 32,
   parameter int DS_TIMEOUT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EXE_Valid,
   input  logic             EXE_Stall,
   input  logic [31:0]      EXE_PC,
   input  btype_t           EXE_BType,
   input  logic             EXE_IsJump,
   input  logic             EXE_Cond,
   input  logic [31:0]      EXE_Target,
   input  PResult           EXE_PResult,
   input  logic             DS_InPipe,
   input  logic             DS_Arrive,
   output BResult           EXE_BResult,
   output logic             Redirect_Valid,
   output logic [31:0]      Redirect_PC,
   output logic             IF_Flush,
   output logic [CNT_W-1:0] Perf_Branch,
   output logic [CNT_W-1:0] Perf_Mispred
);

   // Actual and predicted outcome.
   logic        is_taken_act;
   logic [31:0] fall_pc;
   logic [31:0] next_pc_act;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        mispredict;

   // One-shot resolve event and its qualified consequences.
   logic        resolve;
   logic        inc_branch;
   logic        inc_mispred;
   logic        redirect_now;
   logic        defer_redirect;
   logic        wdog_sat;

   // State.
   brs_state_t              state_q;
   logic                    reported_q;
   logic [31:0]             saved_pc_q;
   logic [DS_TIMEOUT_W-1:0] wdog_q;

   assign fall_pc      = seq_pc(EXE_PC);
   assign is_taken_act = EXE_IsJump | ((EXE_BType == BIsImme) & EXE_Cond);
   assign next_pc_act  = is_taken_act ? EXE_Target : fall_pc;

   // A prediction only counts as taken when the BTB entry was valid.
   assign pred_taken   = EXE_PResult.Valid & EXE_PResult.IsTaken;
   assign pred_pc      = pred_taken ? EXE_PResult.Target : fall_pc;

   // A non-branch predicted taken also lands here and is corrected to PC+8.
   assign mispredict   = EXE_Valid & (next_pc_act != pred_pc);

   // Resolve at most once per instruction, and never while a correction is
   // still waiting for its delay slot.
   assign resolve      = !rst & (state_q == IDLE) & EXE_Valid & !reported_q &
                         ((EXE_BType != BIsNone) | pred_taken);

   assign inc_branch     = resolve & (EXE_BType != BIsNone);
   assign inc_mispred    = resolve & mispredict;
   assign redirect_now   = inc_mispred & DS_InPipe;
   assign defer_redirect = inc_mispred & !DS_InPipe;
   assign wdog_sat       = (wdog_q == '1);

   // Training packet and front-end redirect, both valid in the cycle they apply.
   always_comb begin
      EXE_BResult    = '0;
      Redirect_Valid = 1'b0;
      Redirect_PC    = '0;
      IF_Flush       = 1'b0;

      if (resolve) begin
         EXE_BResult.Valid   = 1'b1;
         EXE_BResult.PC      = EXE_PC;
         EXE_BResult.Type    = EXE_BType;
         EXE_BResult.Target  = EXE_Target;
         EXE_BResult.IsTaken = is_taken_act;
         EXE_BResult.Count   = EXE_PResult.Count;
         EXE_BResult.Hit     = EXE_PResult.Hit;
      end

      // Reset suppresses any redirect, even one coinciding with DS_Arrive.
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (redirect_now) begin
                  Redirect_Valid = 1'b1;
                  IF_Flush       = 1'b1;
                  Redirect_PC    = next_pc_act;
               end
            end
            WAIT_DS: begin
               if (DS_Arrive || wdog_sat) begin
                  Redirect_Valid = 1'b1;
                  IF_Flush       = 1'b1;
                  Redirect_PC    = saved_pc_q;
               end
            end
            default: begin
               Redirect_Valid = 1'b0;
            end
         endcase
      end
   end

   // Resolver FSM, saved correction PC, delay-slot watchdog and one-shot flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         reported_q <= 1'b0;
         saved_pc_q <= '0;
         wdog_q     <= '0;
      end else begin
         // Remember a report made during a stall until EXE finally advances.
         reported_q <= EXE_Stall & (reported_q | resolve);

         case (state_q)
            IDLE: begin
               if (defer_redirect) begin
                  saved_pc_q <= next_pc_act;
                  wdog_q     <= '0;
                  state_q    <= WAIT_DS;
               end
            end
            WAIT_DS: begin
               if (DS_Arrive || wdog_sat) begin
                  state_q <= IDLE;
               end else begin
                  wdog_q <= wdog_q + DS_TIMEOUT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Resolved-branch counter.
   sat_counter #(.W(CNT_W)) u_perf_branch (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_branch),
      .count_o (Perf_Branch)
   );

   // Mispredict counter.
   sat_counter #(.W(CNT_W)) u_perf_mispred (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_mispred),
      .count_o (Perf_Mispred)
   );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of single-cycle resolve
// vectors plus hand-written delay-slot, stall, saturation and reset sequences.
module tb_branch_resolve_unit;
   import CPU_Defines::*;

   localparam int CNT_W = 4;
   localparam int MAXC  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             EXE_Valid;
   logic             EXE_Stall;
   logic [31:0]      EXE_PC;
   btype_t           EXE_BType;
   logic             EXE_IsJump;
   logic             EXE_Cond;
   logic [31:0]      EXE_Target;
   PResult           EXE_PResult;
   logic             DS_InPipe;
   logic             DS_Arrive;
   BResult           EXE_BResult;
   logic             Redirect_Valid;
   logic [31:0]      Redirect_PC;
   logic             IF_Flush;
   logic [CNT_W-1:0] Perf_Branch;
   logic [CNT_W-1:0] Perf_Mispred;

   branch_resolve_unit #(.CNT_W(CNT_W), .DS_TIMEOUT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .EXE_Valid      (EXE_Valid),
      .EXE_Stall      (EXE_Stall),
      .EXE_PC         (EXE_PC),
      .EXE_BType      (EXE_BType),
      .EXE_IsJump     (EXE_IsJump),
      .EXE_Cond       (EXE_Cond),
      .EXE_Target     (EXE_Target),
      .EXE_PResult    (EXE_PResult),
      .DS_InPipe      (DS_InPipe),
      .DS_Arrive      (DS_Arrive),
      .EXE_BResult    (EXE_BResult),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .IF_Flush       (IF_Flush),
      .Perf_Branch    (Perf_Branch),
      .Perf_Mispred   (Perf_Mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      btype_t      btype;
      logic        jump;
      logic        cond;
      logic [31:0] target;
      logic        pv;
      logic        pt;
      logic [31:0] ptgt;
      logic        ds;
      logic        e_bv;
      logic        e_tk;
      logic        e_rv;
      logic [31:0] e_rpc;
      int          db;
      int          dm;
   } vec_t;

   vec_t vecs [11];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   exp_b  = 0;
   int   exp_m  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int sat(input int x, input int d);
      return (x + d > MAXC) ? MAXC : x + d;
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input btype_t bt,
                        input logic j, input logic c, input logic [31:0] tgt,
                        input logic pv, input logic pt, input logic [31:0] ptg,
                        input logic ds);
      EXE_Valid           = v;
      EXE_Stall           = 1'b0;
      EXE_PC              = pc;
      EXE_BType           = bt;
      EXE_IsJump          = j;
      EXE_Cond            = c;
      EXE_Target          = tgt;
      EXE_PResult.Valid   = pv;
      EXE_PResult.IsTaken = pt;
      EXE_PResult.Target  = ptg;
      EXE_PResult.Count   = 2'b10;
      EXE_PResult.Hit     = 1'b1;
      DS_InPipe           = ds;
      DS_Arrive           = 1'b0;
   endtask

   task automatic drive_idle();
      drive(1'b0, 32'h0, BIsNone, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic check_counters(input string tag);
      check({tag, " perf_branch"},  32'(Perf_Branch),  32'(exp_b));
      check({tag, " perf_mispred"}, 32'(Perf_Mispred), 32'(exp_m));
   endtask

   initial begin
      int bv_pulses;
      int rv_pulses;
      logic [31:0] last_rpc;

      //            valid  pc            btype    j  c  target        pv pt ptgt          ds  bv tk rv rpc           db dm
      vecs[0]  = '{1'b1, 32'h0000_1000, BIsImme, 0, 1, 32'h0000_1040, 1, 1, 32'h0000_1040, 0, 1, 1, 0, 32'h0,        1, 0};
      vecs[1]  = '{1'b1, 32'h0000_2000, BIsImme, 0, 0, 32'h0000_2100, 1, 1, 32'h0000_2100, 1, 1, 0, 1, 32'h0000_2008, 1, 1};
      vecs[2]  = '{1'b1, 32'h0000_5000, BIsNone, 0, 0, 32'h0,         1, 1, 32'h0000_6000, 1, 1, 0, 1, 32'h0000_5008, 0, 1};
      vecs[3]  = '{1'b1, 32'h0000_5004, BIsNone, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h0,        0, 0};
      vecs[4]  = '{1'b1, 32'h0000_7000, BIsRetn, 1, 0, 32'h7777_0000, 1, 1, 32'h7777_0004, 1, 1, 1, 1, 32'h7777_0000, 1, 1};
      vecs[5]  = '{1'b1, 32'h0000_7100, BIsCall, 1, 0, 32'h0000_8000, 1, 1, 32'h0000_8000, 1, 1, 1, 0, 32'h0,        1, 0};
      vecs[6]  = '{1'b1, 32'hFFFF_FFF8, BIsImme, 0, 0, 32'h0000_0100, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,        1, 0};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFC, BIsImme, 0, 0, 32'h0000_0100, 1, 1, 32'h0000_0100, 1, 1, 0, 1, 32'h0000_0004, 1, 1};
      vecs[8]  = '{1'b0, 32'h0000_9000, BIsImme, 0, 1, 32'h0000_9100, 1, 1, 32'h0000_1234, 1, 0, 0, 0, 32'h0,        0, 0};
      vecs[9]  = '{1'b1, 32'h0000_8800, BIsImme, 0, 1, 32'h0000_9000, 0, 1, 32'h0000_9000, 1, 1, 1, 1, 32'h0000_9000, 1, 1};
      vecs[10] = '{1'b1, 32'h0000_D000, BIsImme, 0, 0, 32'h0000_D100, 1, 0, 32'h0000_D100, 0, 1, 0, 0, 32'h0,        1, 0};

      // Reset state, with a would-be mispredict on the inputs.
      rst = 1'b1;
      drive(1'b1, 32'h2000, BIsImme, 1'b0, 1'b0, 32'h2100, 1'b1, 1'b1, 32'h2100, 1'b1);
      step();
      step();
      #2;
      check("rst bresult_valid", 32'(EXE_BResult.Valid), 32'd0);
      check("rst redirect",      32'(Redirect_Valid),    32'd0);
      check("rst if_flush",      32'(IF_Flush),          32'd0);
      check_counters("rst");
      rst = 1'b0;
      drive_idle();
      step();

      // Single-cycle resolve vectors.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].valid, vecs[i].pc, vecs[i].btype, vecs[i].jump, vecs[i].cond,
               vecs[i].target, vecs[i].pv, vecs[i].pt, vecs[i].ptgt, vecs[i].ds);
         #2;
         check($sformatf("v%0d bresult_valid", i), 32'(EXE_BResult.Valid), 32'(vecs[i].e_bv));
         if (vecs[i].e_bv) begin
            check($sformatf("v%0d istaken", i), 32'(EXE_BResult.IsTaken), 32'(vecs[i].e_tk));
            check($sformatf("v%0d type", i),    32'(EXE_BResult.Type),    32'(vecs[i].btype));
            check($sformatf("v%0d pc", i),      EXE_BResult.PC,           vecs[i].pc);
            check($sformatf("v%0d target", i),  EXE_BResult.Target,       vecs[i].target);
            check($sformatf("v%0d count", i),   32'(EXE_BResult.Count),   32'd2);
            check($sformatf("v%0d hit", i),     32'(EXE_BResult.Hit),     32'd1);
         end
         check($sformatf("v%0d redirect", i), 32'(Redirect_Valid), 32'(vecs[i].e_rv));
         check($sformatf("v%0d if_flush", i), 32'(IF_Flush),       32'(vecs[i].e_rv));
         if (vecs[i].e_rv) begin
            check($sformatf("v%0d redirect_pc", i), Redirect_PC, vecs[i].e_rpc);
         end
         step();
         exp_b = sat(exp_b, vecs[i].db);
         exp_m = sat(exp_m, vecs[i].dm);
         check_counters($sformatf("v%0d", i));
      end

      // jal with the delay slot not yet fetched: redirect waits for DS_Arrive.
      drive(1'b1, 32'h3000, BIsCall, 1'b1, 1'b0, 32'h4000, 1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      check("jal bresult_valid", 32'(EXE_BResult.Valid), 32'd1);
      check("jal no early redirect c0", 32'(Redirect_Valid), 32'd0);
      step();
      exp_b = sat(exp_b, 1);
      exp_m = sat(exp_m, 1);
      drive_idle();
      for (int k = 1; k < 3; k++) begin
         #2;
         check($sformatf("jal no early redirect c%0d", k), 32'(Redirect_Valid), 32'd0);
         step();
      end
      DS_Arrive = 1'b1;
      #2;
      check("jal ds redirect",    32'(Redirect_Valid), 32'd1);
      check("jal ds redirect_pc", Redirect_PC,         32'h4000);
      check("jal ds if_flush",    32'(IF_Flush),       32'd1);
      step();
      DS_Arrive = 1'b0;
      #2;
      check("jal redirect one-shot", 32'(Redirect_Valid), 32'd0);
      step();
      check_counters("jal");

      // Delay slot never shows up: watchdog forces the redirect after 16 cycles.
      drive(1'b1, 32'hA000, BIsImme, 1'b0, 1'b0, 32'hA100, 1'b1, 1'b1, 32'hA100, 1'b0);
      step();
      exp_b = sat(exp_b, 1);
      exp_m = sat(exp_m, 1);
      drive_idle();
      rv_pulses = 0;
      for (int k = 1; k < 16; k++) begin
         #2;
         if (Redirect_Valid) rv_pulses++;
         step();
      end
      check("wdog early redirects", 32'(rv_pulses), 32'd0);
      #2;
      check("wdog redirect",    32'(Redirect_Valid), 32'd1);
      check("wdog redirect_pc", Redirect_PC,         32'hA008);
      step();
      #2;
      check("wdog back to idle", 32'(Redirect_Valid), 32'd0);
      step();
      check_counters("wdog");

      // Mispredicted branch stalled in EXE for 4 cycles: exactly one report.
      drive(1'b1, 32'hB000, BIsImme, 1'b0, 1'b0, 32'hB040, 1'b1, 1'b1, 32'hB040, 1'b1);
      bv_pulses = 0;
      rv_pulses = 0;
      last_rpc  = 32'h0;
      for (int k = 0; k < 5; k++) begin
         EXE_Stall = (k < 4);
         #2;
         if (EXE_BResult.Valid) bv_pulses++;
         if (Redirect_Valid) begin
            rv_pulses++;
            last_rpc = Redirect_PC;
         end
         step();
      end
      exp_b = sat(exp_b, 1);
      exp_m = sat(exp_m, 1);
      check("stall bresult pulses", 32'(bv_pulses), 32'd1);
      check("stall redirect pulses", 32'(rv_pulses), 32'd1);
      check("stall redirect_pc", last_rpc, 32'hB008);
      check_counters("stall");

      // Next instruction after the stall resolves normally.
      drive(1'b1, 32'hB100, BIsImme, 1'b0, 1'b1, 32'hB200, 1'b1, 1'b1, 32'hB200, 1'b0);
      #2;
      check("post-stall bresult_valid", 32'(EXE_BResult.Valid), 32'd1);
      step();
      exp_b = sat(exp_b, 1);

      // Drive the mispredict counter up to all-ones, then one more.
      while (exp_m < MAXC) begin
         drive(1'b1, 32'h2000, BIsImme, 1'b0, 1'b0, 32'h2100, 1'b1, 1'b1, 32'h2100, 1'b1);
         step();
         exp_b = sat(exp_b, 1);
         exp_m = sat(exp_m, 1);
      end
      check_counters("sat reach");
      drive(1'b1, 32'h2000, BIsImme, 1'b0, 1'b0, 32'h2100, 1'b1, 1'b1, 32'h2100, 1'b1);
      step();
      exp_b = sat(exp_b, 1);
      exp_m = sat(exp_m, 1);
      check_counters("sat hold");

      // Reset while waiting for the delay slot, coinciding with DS_Arrive.
      drive(1'b1, 32'hC000, BIsImme, 1'b0, 1'b0, 32'hC100, 1'b1, 1'b1, 32'hC100, 1'b0);
      step();
      drive_idle();
      rst       = 1'b1;
      DS_Arrive = 1'b1;
      #2;
      check("rst+ds redirect", 32'(Redirect_Valid), 32'd0);
      step();
      rst   = 1'b0;
      exp_b = 0;
      exp_m = 0;
      check_counters("post-rst");
      #2;
      check("post-rst ds redirect", 32'(Redirect_Valid), 32'd0);
      step();
      DS_Arrive = 1'b0;
      rv_pulses = 0;
      for (int k = 0; k < 20; k++) begin
         #2;
         if (Redirect_Valid) rv_pulses++;
         step();
      end
      check("post-rst no late redirect", 32'(rv_pulses), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
